key_evt: RTL and testbench
==========================

# key_evt

Button event decoder sitting directly downstream of the debouncer: it takes the debounced key level and turns it into single-cycle event pulses (press, release, long-press, auto-repeat), a held flag and a wrapping press count. Typical consumers are the board counters, menu FSMs and display logic, which need one clean pulse per user action rather than a level. The input is treated as asynchronous to `clk`, because the debouncer output is not guaranteed to be registered in this clock domain.

## Interface
Parameters:
- `LONG`, 100_000_000: cycles the key must stay held after the press pulse before `lng` fires (1 s at 100 MHz); must be ≥ 2.
- `RPT`, 20_000_000: auto-repeat period in cycles after `lng`; must be ≥ 2.
- `CW`, 27: internal hold-counter width; must satisfy 2^CW > max(LONG, RPT).

Ports:
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `x`, input, 1: debounced key level, 1 = pressed; asynchronous.
- `prs`, output, 1: one-cycle pulse on press.
- `rel`, output, 1: one-cycle pulse on release.
- `lng`, output, 1: one-cycle pulse when the long-press threshold is reached.
- `rep`, output, 1: one-cycle pulse every `RPT` cycles after `lng` while the key is still held.
- `held`, output, 1: high while the FSM is not in IDLE.
- `npr`, output, 8: count of `prs` pulses; wraps 255→0.

## Operation
- Synchronizer: two flops, s1 ← x and s2 ← s1. All decisions use s2.
- FSM states are IDLE, DOWN and REPT. Hold counter `cnt` is CW bits wide.
- IDLE:
  - If s2=1: go to DOWN, cnt←0, prs←1, npr←npr+1.
  - Otherwise stay in IDLE.
- DOWN:
  - If s2=0: go to IDLE, rel←1.
  - Else if cnt==LONG-1: go to REPT, cnt←0, lng←1.
  - Else cnt←cnt+1.
- REPT:
  - If s2=0: go to IDLE, rel←1.
  - Else if cnt==RPT-1: cnt←0, rep←1.
  - Else cnt←cnt+1.
- All pulse outputs are registered and default to 0 on every cycle in which they are not set.
- `held` is registered and equals (next state ≠ IDLE).
- Simultaneous events:
  - Release wins over a threshold hit in the same cycle. `rel` fires; no `lng` or `rep` fires.
  - At most one pulse output is high in any cycle.
- `cnt` does not advance in IDLE. `npr` changes only together with `prs`.

## Timing
- Reset (rstn=0, asynchronous): s1=s2=0, state=IDLE, cnt=0, prs=rel=lng=rep=held=0, npr=0.
- Press latency: x rises before edge E1. s1=1 at E1, s2=1 at E2, then prs=1, held=1 and npr increments at E3. prs drops at E4.
- Release latency: x falls before edge F1. rel=1 and held=0 at F3.
- `lng` rises exactly LONG edges after the `prs` edge.
- First `rep` rises RPT edges after the `lng` edge, then every RPT edges.
- Minimum press width: a high level on s2 of 1 cycle produces `prs` then `rel` on consecutive edges.
- Reset deasserted with x already high: the press is detected normally, with prs at the 3rd edge after deassertion.
- Reset asserted mid-hold: all outputs clear immediately. No `rel` is generated for the interrupted press.

## Test plan
Benches use LONG=10, RPT=4.
- Reset then short press: release rstn, x=1 for 5 cycles, then x=0 → prs high 1 cycle at edge 3, rel at 3 edges after the fall, held high between them, npr=1, no lng/rep.
- Long hold with repeat: x=1 for 30 cycles → prs at E, lng at E+10, rep at E+14, E+18, E+22, E+26, rel 3 edges after x falls.
- Release racing the threshold: x=1, timed so s2 drops in the same cycle cnt==LONG-1 → rel=1, lng stays 0, state returns to IDLE.
- Counter wrap: 256 short presses → npr reads 255 after the 255th press and 0 after the 256th.
- Reset mid-hold: assert rstn=0 3 cycles after lng → all outputs 0 immediately, no rel. Deassert with x=1 → fresh prs at the 3rd edge, npr=1.
- Async glitch: x pulses high for less than one clock, between edges → no prs. A single-cycle s2 high → prs and rel on consecutive edges.

Source files
------------

// File: rtl/key_evt.sv
// Button event decoder: turns a debounced, asynchronous key level into single-cycle
// press/release/long-press/auto-repeat pulses, a held flag and a wrapping press count.
module key_evt #(
  parameter int unsigned LONG = 100_000_000,
  parameter int unsigned RPT  = 20_000_000,
  parameter int unsigned CW   = 27
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       x,
  output logic       prs,
  output logic       rel,
  output logic       lng,
  output logic       rep,
  output logic       held,
  output logic [7:0] npr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DOWN = 2'd1;
  localparam logic [1:0] REPT = 2'd2;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT - 1);

  logic          s1, s2;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prs_d, rel_d, lng_d, rep_d;
  logic [7:0]    npr_d;

  // Release is tested before the threshold so it always wins a same-cycle race.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    prs_d = 1'b0;
    rel_d = 1'b0;
    lng_d = 1'b0;
    rep_d = 1'b0;
    npr_d = npr;
    case (st_q)
      IDLE: begin
        if (s2) begin
          st_d  = DOWN;
          cnt_d = '0;
          prs_d = 1'b1;
          npr_d = npr + 8'd1;
        end
      end
      DOWN: begin
        if (!s2) begin
          st_d  = IDLE;
          rel_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          st_d  = REPT;
          cnt_d = '0;
          lng_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPT: begin
        if (!s2) begin
          st_d  = IDLE;
          rel_d = 1'b1;
        end else if (cnt_q == RPT_LAST) begin
          cnt_d = '0;
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      st_q  <= IDLE;
      cnt_q <= '0;
      prs   <= 1'b0;
      rel   <= 1'b0;
      lng   <= 1'b0;
      rep   <= 1'b0;
      held  <= 1'b0;
      npr   <= 8'd0;
    end else begin
      s1    <= x;
      s2    <= s1;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      prs   <= prs_d;
      rel   <= rel_d;
      lng   <= lng_d;
      rep   <= rep_d;
      held  <= (st_d != IDLE);
      npr   <= npr_d;
    end
  end

endmodule

// File: tb/tb_key_evt.sv
// Directed bench for key_evt with LONG=10, RPT=4; edges are numbered from 1 after each stimulus
// change and the sampled outputs are kept per edge for checking.
module tb_key_evt;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       x = 1'b0;
  logic       prs, rel, lng, rep, held;
  logic [7:0] npr;

  int n_chk = 0;
  int n_err = 0;
  int onehot_bad = 0;

  // Per-edge sample: {prs, rel, lng, rep, held}
  logic [4:0] hist[$];

  localparam int B_PRS  = 4;
  localparam int B_REL  = 3;
  localparam int B_LNG  = 2;
  localparam int B_REP  = 1;
  localparam int B_HELD = 0;

  key_evt #(.LONG(10), .RPT(4), .CW(8)) dut (
    .clk (clk),
    .rstn(rstn),
    .x   (x),
    .prs (prs),
    .rel (rel),
    .lng (lng),
    .rep (rep),
    .held(held),
    .npr (npr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      hist.push_back({prs, rel, lng, rep, held});
      if ((int'(prs) + int'(rel) + int'(lng) + int'(rep)) > 1) onehot_bad++;
    end
  endtask

  function automatic int first_at(input int b);
    for (int i = 0; i < hist.size(); i++) if (hist[i][b]) return i + 1;
    return 0;
  endfunction

  function automatic int count_of(input int b);
    int c = 0;
    for (int i = 0; i < hist.size(); i++) if (hist[i][b]) c++;
    return c;
  endfunction

  function automatic int at(input int e, input int b);
    if (e < 1 || e > hist.size()) return -1;
    return int'(hist[e-1][b]);
  endfunction

  initial begin
    // Reset state
    cycles(2);
    check("rst_outs", int'({prs, rel, lng, rep, held}), 0);
    check("rst_npr", int'(npr), 0);

    // Short press released out of reset with x already high
    rstn = 1'b1;
    x = 1'b1;
    hist.delete();
    cycles(5);
    x = 1'b0;
    cycles(6);
    check("short_prs_edge", first_at(B_PRS), 3);
    check("short_prs_cnt", count_of(B_PRS), 1);
    check("short_rel_edge", first_at(B_REL), 8);
    check("short_held_e2", at(2, B_HELD), 0);
    check("short_held_e3", at(3, B_HELD), 1);
    check("short_held_e7", at(7, B_HELD), 1);
    check("short_held_e8", at(8, B_HELD), 0);
    check("short_no_lng_rep", count_of(B_LNG) + count_of(B_REP), 0);
    check("short_npr", int'(npr), 1);

    // Long hold with auto-repeat; the repeat due at edge 33 loses to the release
    x = 1'b1;
    hist.delete();
    cycles(30);
    x = 1'b0;
    cycles(6);
    check("long_prs_edge", first_at(B_PRS), 3);
    check("long_lng_edge", first_at(B_LNG), 13);
    check("long_lng_cnt", count_of(B_LNG), 1);
    check("long_rep_first", first_at(B_REP), 17);
    check("long_rep_e21", at(21, B_REP), 1);
    check("long_rep_e25", at(25, B_REP), 1);
    check("long_rep_e29", at(29, B_REP), 1);
    check("long_rep_cnt", count_of(B_REP), 4);
    check("long_rel_edge", first_at(B_REL), 33);
    check("long_held_e32", at(32, B_HELD), 1);
    check("long_npr", int'(npr), 2);

    // s2 drops exactly when cnt reaches LONG-1
    x = 1'b1;
    hist.delete();
    cycles(10);
    x = 1'b0;
    cycles(6);
    check("race_rel_edge", first_at(B_REL), 13);
    check("race_no_lng", count_of(B_LNG), 0);
    check("race_held_e12", at(12, B_HELD), 1);
    check("race_held_e13", at(13, B_HELD), 0);

    // Counter wrap from a fresh reset
    rstn = 1'b0;
    #1;
    check("wrap_rst_npr", int'(npr), 0);
    cycles(2);
    rstn = 1'b1;
    hist.delete();
    for (int p = 1; p <= 256; p++) begin
      x = 1'b1;
      cycles(2);
      x = 1'b0;
      cycles(3);
      if (p == 255) check("wrap_npr_255", int'(npr), 255);
    end
    check("wrap_npr_0", int'(npr), 0);
    check("wrap_prs_cnt", count_of(B_PRS), 256);

    // Reset asserted three edges after lng
    x = 1'b1;
    hist.delete();
    cycles(16);
    check("mid_lng_edge", first_at(B_LNG), 13);
    rstn = 1'b0;
    #1;
    check("mid_rst_outs", int'({prs, rel, lng, rep, held}), 0);
    check("mid_rst_npr", int'(npr), 0);
    cycles(3);
    rstn = 1'b1;
    hist.delete();
    cycles(6);
    check("mid_prs_edge", first_at(B_PRS), 3);
    check("mid_no_rel", count_of(B_REL), 0);
    check("mid_npr", int'(npr), 1);

    // Sub-cycle glitch between edges, then a single-cycle s2 pulse
    x = 1'b0;
    cycles(5);
    hist.delete();
    #2 x = 1'b1;
    #3 x = 1'b0;
    cycles(6);
    check("glitch_no_prs", count_of(B_PRS), 0);
    x = 1'b1;
    hist.delete();
    cycles(1);
    x = 1'b0;
    cycles(5);
    check("min_prs_edge", first_at(B_PRS), 3);
    check("min_rel_edge", first_at(B_REL), 4);
    check("min_held_e3", at(3, B_HELD), 1);
    check("min_held_e4", at(4, B_HELD), 0);
    check("min_npr", int'(npr), 2);

    check("onehot", onehot_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
